// File: rtl/wordle_scorer.sv
// Sequential Wordle scorer: one position per cycle for greens, then a linear
// scan of the target for each non-green guess letter to award yellows.
module wordle_scorer (
   input  logic        Clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [39:0] guess,
   input  logic [39:0] target,
   output logic        Busy,
   output logic        Done,
   output logic [4:0]  green,
   output logic [4:0]  yellow,
   output logic        match
);

   typedef enum logic [3:0] {
      IDLE   = 4'b0001,
      GREEN  = 4'b0010,
      YELLOW = 4'b0100,
      DONE   = 4'b1000
   } state_t;

   state_t      state;
   logic [7:0]  guess_q  [5];
   logic [7:0]  target_q [5];
   logic [2:0]  i;
   logic [2:0]  j;
   logic [4:0]  used;
   logic        yel_hit;
   logic        yel_adv;

   // A yellow claims the first unused target slot holding the letter; a green
   // position, a claim, or the end of the scan all move on to the next letter.
   always_comb begin
      yel_hit = 1'b0;
      yel_adv = 1'b0;
      if (state == YELLOW) begin
         yel_hit = !green[i] && (guess_q[i] == target_q[j]) && !used[j];
         yel_adv = green[i] || yel_hit || (j == 3'd4);
      end
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         Busy   <= 1'b0;
         Done   <= 1'b0;
         green  <= '0;
         yellow <= '0;
         match  <= 1'b0;
         i      <= '0;
         j      <= '0;
         used   <= '0;
         for (int p = 0; p < 5; p++) begin
            guess_q[p]  <= '0;
            target_q[p] <= '0;
         end
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  for (int p = 0; p < 5; p++) begin
                     guess_q[p]  <= guess[39-8*p -: 8];
                     target_q[p] <= target[39-8*p -: 8];
                  end
                  green  <= '0;
                  yellow <= '0;
                  match  <= 1'b0;
                  used   <= '0;
                  i      <= '0;
                  j      <= '0;
                  Busy   <= 1'b1;
                  state  <= GREEN;
               end
            end
            GREEN: begin
               if (guess_q[i] == target_q[i]) begin
                  green[i] <= 1'b1;
                  used[i]  <= 1'b1;
               end
               if (i == 3'd4) begin
                  i     <= '0;
                  j     <= '0;
                  state <= YELLOW;
               end else begin
                  i <= i + 3'd1;
               end
            end
            YELLOW: begin
               if (yel_hit) begin
                  yellow[i] <= 1'b1;
                  used[j]   <= 1'b1;
               end
               if (yel_adv) begin
                  j <= '0;
                  if (i == 3'd4) begin
                     i     <= '0;
                     Done  <= 1'b1;
                     match <= &green;
                     state <= DONE;
                  end else begin
                     i <= i + 3'd1;
                  end
               end else begin
                  j <= j + 3'd1;
               end
            end
            DONE: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/wordle_scorer.md
WORDLE_SCORER -- requirements
Module: wordle_scorer

Interface
- REQ-001: Clk  input  1  system clock; all state changes on its rising edge.
- REQ-002: reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, independent of Clk.
- REQ-003: Start  input  1  scoring request, sampled on rising edges of Clk in IDLE only.
- REQ-004: guess  input  40  five 8-bit ASCII letters; position 0 = guess[39:32] through position 4 = guess[7:0].
- REQ-005: target  input  40  word of the day, same packing as guess.
- REQ-006: Busy  output  1  high in every state except IDLE.
- REQ-007: Done  output  1  one-cycle pulse; results valid.
- REQ-008: green  output  5  bit p high when guess position p equals target position p.
- REQ-009: yellow  output  5  bit p high when guess letter p occurs at a different, not-yet-claimed target position.
- REQ-010: match  output  1  high when all five green bits are set.

Function
- REQ-011: The FSM shall be one-hot with states IDLE, GREEN, YELLOW and DONE.
- REQ-012: In IDLE with Start high at a rising edge, the block shall:
  - capture guess and target into internal registers;
  - clear green, yellow, match and the 5-bit target-used mask;
  - set position counter i=0;
  - enter GREEN.
- REQ-013: Inputs guess and target shall be don't-care after the capture edge.
- REQ-014: GREEN shall take exactly one cycle per position, i=0..4:
  - if captured guess[i] equals target[i], set green[i] and used[i];
  - after i=4, enter YELLOW with i=0 and j=0.
- REQ-015: YELLOW, per cycle:
  - if green[i] is set, advance i and reset j=0 (one cycle);
  - otherwise, if guess[i] equals target[j] and used[j]=0, set yellow[i] and used[j], then advance i and reset j=0;
  - otherwise, if j=4, advance i and reset j=0;
  - otherwise, increment j.
- REQ-016: Advancing i past 4 shall enter DONE; i and j shall be 3-bit counters that never exceed 4.
- REQ-017: A target position shall be claimed by at most one green or yellow; duplicate guess letters beyond the target's count shall score neither colour.
- REQ-018: DONE shall last one cycle:
  - assert Done;
  - load match = AND of green;
  - return to IDLE.
- REQ-019: green, yellow and match shall hold their values from DONE until the next accepted Start.
- REQ-020: Latency, counted from the Start-sampling edge to Done high:
  - 10 cycles when all positions are green;
  - 30 cycles maximum;
  - 5 + sum of per-position YELLOW cycles in general.
- REQ-021: Start in any state other than IDLE shall be ignored and shall not be queued.
- REQ-022: Start held high continuously shall start a new scoring on the IDLE cycle that follows each DONE.
- REQ-023: Letter comparison shall be exact 8-bit equality with no case folding.

Reset
- REQ-024: reset low shall immediately force:
  - state IDLE;
  - Busy=0, Done=0;
  - green=0, yellow=0, match=0;
  - i=0, j=0, used=0.
- REQ-025: reset asserted mid-scoring shall abort the operation with no Done pulse.
- REQ-026: After reset deasserts, the block shall accept Start on the first rising edge.

Verification
- REQ-027: guess "ROBOT", target "ROBOT", Start pulse -> Done 10 cycles after the Start edge; green=11111, yellow=00000, match=1; Busy high for 11 cycles.
- REQ-028: guess "ROBIN", target "ROBOT" -> green=00111, yellow=00000, match=0.
- REQ-029: guess "OOOOO", target "ONION" -> green=01001, yellow=00000 (duplicates consumed by greens).
- REQ-030: guess "ABBOT", target "BANAL" -> green=00000, yellow=00011 (second B unscored); Done 23 cycles after the Start edge.
- REQ-031: Start pulsed again during Busy with a different guess -> ignored; results match the first guess; exactly one Done.
- REQ-032: reset low in cycle 7 of a scoring -> outputs zero immediately, no Done; a new Start after release scores correctly.
